// File: rtl/ifetch_queue_pkg.sv
// Shared widths, queue entry layout and PC helper for the instruction fetch queue.
package ifetch_queue_pkg;

    localparam int FULLW      = 32;
    localparam int IFQ_ENTRYW = 2 * FULLW;

    typedef struct packed {
        logic [FULLW-1:0] pc;
        logic [FULLW-1:0] instr;
    } ifq_entry_t;

    function automatic logic [FULLW-1:0] pc_next(input logic [FULLW-1:0] pc);
        return pc + FULLW'(4);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered head, flush, and occupancy count; no write-to-read bypass.
module fifo_sync #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign pop_ok = pop & ~empty;
    // Gate the head so the outputs read zero whenever nothing is valid.
    assign rdata  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, issues one RAM read per cycle under a queue credit, buffers words for the decoder.
// Optional IFETCH_PERF_EN adds perf_fetched / perf_flushed event counters.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [FULLW-1:0] imem_addr,
    input  logic [FULLW-1:0] imem_rdata,
    input  logic             br_valid,
    input  logic [FULLW-1:0] br_target,
    output logic             instr_valid,
    output logic [FULLW-1:0] instr,
    output logic [FULLW-1:0] instr_pc,
    input  logic             instr_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [FULLW-1:0] pc_q, pc_d, inflight_pc_q;
    logic             inflight_q;
    logic [CW-1:0]    count;
    logic [CW:0]      occupancy;
    logic             empty, issue, push, xfer;
    ifq_entry_t       wentry, head;

    assign imem_addr   = pc_q;
    assign instr_valid = ~empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign xfer        = instr_valid & instr_ready;

    // Queued plus in-flight words must fit, so every returning word has a slot.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
    assign issue     = ~br_valid & (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_q & ~br_valid;

    always_comb begin
        wentry       = '0;
        wentry.pc    = inflight_pc_q;
        wentry.instr = imem_rdata;
    end

    always_comb begin
        pc_d = pc_q;
        if (br_valid) begin
            pc_d = br_target & ~FULLW'(3);
        end else if (issue) begin
            pc_d = pc_next(pc_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fifo_sync #(
        .WIDTH (IFQ_ENTRYW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (br_valid),
        .push  (push),
        .wdata (wentry),
        .pop   (xfer),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] fetched_q, flushed_q, dropped;

    // A head consumed in the redirect cycle is a transfer, not a discard.
    assign dropped = br_valid ? (32'(count) - 32'(xfer) + 32'(inflight_q)) : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(xfer);
            flushed_q <= flushed_q + dropped;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: startup, stall/drain, redirects, PC wrap on a second instance.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [31:0] imem_addr, imem_rdata, imem_addr2, imem_rdata2;
    logic        br_valid;
    logic [31:0] br_target;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr, instr_pc, instr2, instr_pc2;
    logic        instr_ready, instr_ready2;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_fetched2, perf_flushed2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= ram_word(imem_addr);
        imem_rdata2 <= ram_word(imem_addr2);
    end

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk), .reset (reset),
        .imem_addr (imem_addr), .imem_rdata (imem_rdata),
        .br_valid (br_valid), .br_target (br_target),
        .instr_valid (instr_valid), .instr (instr), .instr_pc (instr_pc),
        .instr_ready (instr_ready)
`ifdef IFETCH_PERF_EN
        , .perf_fetched (perf_fetched), .perf_flushed (perf_flushed)
`endif
    );

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk (clk), .reset (reset2),
        .imem_addr (imem_addr2), .imem_rdata (imem_rdata2),
        .br_valid (1'b0), .br_target (32'h0),
        .instr_valid (instr_valid2), .instr (instr2), .instr_pc (instr_pc2),
        .instr_ready (instr_ready2)
`ifdef IFETCH_PERF_EN
        , .perf_fetched (perf_fetched2), .perf_flushed (perf_flushed2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        instr_ready = 1'b1; instr_ready2 = 1'b1;
        br_valid = 1'b0; br_target = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

        // Test 1: startup with ready held high; dut2 wraps from FFFF_FFF8.
        reset = 1'b0; reset2 = 1'b0;
        step();
        chk("t1_c1_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("t1_c2_valid", {31'b0, instr_valid}, 32'h1);
        chk("t1_c2_pc", instr_pc, 32'h0);
        chk("t1_c2_instr", instr, 32'hA000_0000);
        chk("t6_pc_fff8", instr_pc2, 32'hFFFF_FFF8);
        chk("t6_instr_fff8", instr2, 32'hA000_0000 + 32'h3FFF_FFFE);
        step();
        chk("t1_c3_pc", instr_pc, 32'h4);
        chk("t1_c3_instr", instr, 32'hA000_0001);
        chk("t6_pc_fffc", instr_pc2, 32'hFFFF_FFFC);
        step();
        chk("t1_c4_pc", instr_pc, 32'h8);
        chk("t1_c4_instr", instr, 32'hA000_0002);
        chk("t6_pc_0", instr_pc2, 32'h0);
        chk("t6_valid_0", {31'b0, instr_valid2}, 32'h1);
        step();
        chk("t1_c5_pc", instr_pc, 32'hC);
        chk("t1_c5_instr", instr, 32'hA000_0003);
`ifdef IFETCH_PERF_EN
        chk("t6_perf_fetched", perf_fetched2, 32'd3);
`endif

        // Asynchronous reset mid-operation.
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc", instr_pc, 32'h0);
        instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Test 2: stall fills the queue, then drain with no gap or duplicate.
        repeat (10) step();
        chk("t2_full_valid", {31'b0, instr_valid}, 32'h1);
        chk("t2_full_pc", instr_pc, 32'h0);
        chk("t2_addr_frozen", imem_addr, 32'h10);
        instr_ready = 1'b1;
        step();
        chk("t2_d1_pc", instr_pc, 32'h4);
        step();
        chk("t2_d2_pc", instr_pc, 32'h8);
        step();
        chk("t2_d3_pc", instr_pc, 32'hC);
        step();
        chk("t2_d4_pc", instr_pc, 32'h10);
        chk("t2_d4_instr", instr, 32'hA000_0004);
        chk("t2_d4_valid", {31'b0, instr_valid}, 32'h1);
        step();
        chk("t2_d5_pc", instr_pc, 32'h14);

        // Test 3: redirect while three entries are queued and one is in flight.
        reset = 1'b1; instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("t3_pre_pc", instr_pc, 32'h0);
        chk("t3_pre_addr", imem_addr, 32'h10);
        br_valid = 1'b1; br_target = 32'h40;
        step();
        br_valid = 1'b0;
        chk("t3_t1_valid", {31'b0, instr_valid}, 32'h0);
        chk("t3_t1_addr", imem_addr, 32'h40);
`ifdef IFETCH_PERF_EN
        chk("t3_perf_flushed", perf_flushed, 32'd4);
        chk("t3_perf_fetched", perf_fetched, 32'd0);
`endif
        step();
        chk("t3_t2_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("t3_t3_valid", {31'b0, instr_valid}, 32'h1);
        chk("t3_t3_pc", instr_pc, 32'h40);
        chk("t3_t3_instr", instr, 32'hA000_0010);
        instr_ready = 1'b1;
        step();
        chk("t3_next_pc", instr_pc, 32'h44);
        step();
        chk("t3_next2_pc", instr_pc, 32'h48);

        // Test 4: redirect in the same cycle pc 0x8 is consumed; unaligned target.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("t4_pre_pc", instr_pc, 32'h8);
        br_valid = 1'b1; br_target = 32'h43;
        step();
        br_valid = 1'b0;
        chk("t4_t1_valid", {31'b0, instr_valid}, 32'h0);
        chk("t4_t1_addr", imem_addr, 32'h40);
`ifdef IFETCH_PERF_EN
        chk("t4_perf_fetched", perf_fetched, 32'd3);
        chk("t4_perf_flushed", perf_flushed, 32'd1);
`endif
        step();
        chk("t4_t2_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("t4_t3_valid", {31'b0, instr_valid}, 32'h1);
        chk("t4_t3_pc", instr_pc, 32'h40);

        // Test 5: back-to-back redirects, last target wins.
        br_valid = 1'b1; br_target = 32'h80;
        step();
        chk("t5_b1_valid", {31'b0, instr_valid}, 32'h0);
        br_target = 32'h100;
        step();
        br_valid = 1'b0;
        chk("t5_b2_valid", {31'b0, instr_valid}, 32'h0);
        chk("t5_b2_addr", imem_addr, 32'h100);
        step();
        chk("t5_b3_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("t5_b4_valid", {31'b0, instr_valid}, 32'h1);
        chk("t5_b4_pc", instr_pc, 32'h100);
        chk("t5_b4_instr", instr, 32'hA000_0040);
`ifdef IFETCH_PERF_EN
        chk("t5_perf_fetched", perf_fetched, 32'd4);
        chk("t5_perf_flushed", perf_flushed, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
